// File: rtl/frame_tracker_fsm.sv
// Frame tracker: follows the accepted beats of an Ethernet-over-AXI-Stream
// link, resolves stacked VLAN tags, tracks header/payload phase and reports
// per-frame length and error flags.
//
// Handshake: beat_accept is the already-qualified tvalid && tready of the
// monitored stream. A beat is consumed only in a cycle where beat_accept is
// high. The tracker never back-pressures, and it ignores tdata/tkeep/tlast
// in every other cycle.
module frame_tracker_fsm #(
    parameter int DATA_BYTES      = 1,
    parameter int MAX_VLAN_TAGS   = 2,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int CNT_W           = $clog2(MAX_FRAME_BYTES + DATA_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    beat_accept,
    input  logic [8*DATA_BYTES-1:0] tdata,
    input  logic [DATA_BYTES-1:0]   tkeep,
    input  logic                    tlast,
    output logic                    frame_start,
    output logic                    in_header,
    output logic                    in_payload,
    output logic                    header_done,
    output logic [4:0]              hdr_len,
    output logic [1:0]              vlan_tags,
    output logic [CNT_W-1:0]        frame_len,
    output logic                    frame_end,
    output logic                    err_runt,
    output logic                    err_oversize,
    output logic                    err_truncated,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        DISCARD = 3'd3,
        END     = 3'd4
    } state_t;

    // At least one TPID slot is kept so the arrays stay legal when tags are disabled.
    localparam int TAG_SLOTS = (MAX_VLAN_TAGS > 0) ? MAX_VLAN_TAGS : 1;
    localparam int SUM_W     = CNT_W + 1;
    localparam logic [SUM_W-1:0] CNT_SAT = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_FRAME_BYTES);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_FRAME_BYTES);

    state_t           state;
    logic [CNT_W-1:0] byte_count;
    // TPID bytes seen so far, so a field split across beats can still be resolved.
    logic [7:0]       tpid_hi_q [TAG_SLOTS];
    logic [7:0]       tpid_lo_q [TAG_SLOTS];

    logic             starting;
    logic [CNT_W-1:0] base_count;
    logic [SUM_W-1:0] sum_count;
    logic [CNT_W-1:0] new_count;
    logic [7:0]       tpid_hi_d [TAG_SLOTS];
    logic [7:0]       tpid_lo_d [TAG_SLOTS];
    logic [1:0]       tags_next;
    logic [4:0]       hdr_len_next;
    logic             hdr_complete;
    logic             runt_now;
    logic             over_now;

    function automatic logic [SUM_W-1:0] keep_count(input logic [DATA_BYTES-1:0] keep);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < DATA_BYTES; i++) n = n + SUM_W'(keep[i]);
        return n;
    endfunction

    function automatic logic is_tpid(input logic [7:0] hi, input logic [7:0] lo);
        return ({hi, lo} == 16'h8100) || ({hi, lo} == 16'h88A8);
    endfunction

    // A beat taken in IDLE or END opens a new frame. It is held low during reset.
    assign starting    = beat_accept && !rst && ((state == IDLE) || (state == END));
    assign frame_start = starting;
    assign in_header   = (state == HEADER);
    assign in_payload  = (state == PAYLOAD) || (state == DISCARD);
    assign state_dbg   = state;

    // Per-beat byte accounting and header resolution for the beat on the bus.
    always_comb begin
        base_count = starting ? '0 : byte_count;
        sum_count  = {1'b0, base_count} + keep_count(tkeep);
        new_count  = (sum_count > CNT_SAT) ? CNT_SAT[CNT_W-1:0] : sum_count[CNT_W-1:0];
        runt_now   = new_count < MIN_LEN;
        over_now   = new_count > MAX_LEN;

        // Merge the TPID bytes from this beat into the ones already captured.
        for (int k = 0; k < TAG_SLOTS; k++) begin
            tpid_hi_d[k] = starting ? 8'h00 : tpid_hi_q[k];
            tpid_lo_d[k] = starting ? 8'h00 : tpid_lo_q[k];
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (tkeep[i] && (base_count + CNT_W'(i) == CNT_W'(12 + 4 * k)))
                    tpid_hi_d[k] = tdata[8*i +: 8];
                if (tkeep[i] && (base_count + CNT_W'(i) == CNT_W'(13 + 4 * k)))
                    tpid_lo_d[k] = tdata[8*i +: 8];
            end
        end

        // Tag k counts only once its TPID is fully received and tag k-1 was found.
        tags_next = starting ? 2'd0 : vlan_tags;
        for (int k = 0; k < MAX_VLAN_TAGS; k++) begin
            if ((tags_next == 2'(k)) && (new_count > CNT_W'(13 + 4 * k)) &&
                is_tpid(tpid_hi_d[k], tpid_lo_d[k]))
                tags_next = 2'(k + 1);
        end

        // Once the count covers the resolved length, the field at hdr_len-2 has
        // already been judged non-TPID, or the tag limit was reached.
        hdr_len_next = 5'd14 + {1'b0, tags_next, 2'b00};
        hdr_complete = new_count >= CNT_W'(hdr_len_next);
    end

    // Frame phase, byte counter, TPID capture and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            byte_count    <= '0;
            header_done   <= 1'b0;
            hdr_len       <= 5'd14;
            vlan_tags     <= 2'd0;
            frame_len     <= '0;
            frame_end     <= 1'b0;
            err_runt      <= 1'b0;
            err_oversize  <= 1'b0;
            err_truncated <= 1'b0;
            for (int k = 0; k < TAG_SLOTS; k++) begin
                tpid_hi_q[k] <= 8'h00;
                tpid_lo_q[k] <= 8'h00;
            end
        end else begin
            header_done <= 1'b0;
            frame_end   <= 1'b0;
            if (state == END) state <= IDLE;
            if (beat_accept) begin
                byte_count <= new_count;
                case (state)
                    IDLE, END, HEADER: begin
                        if (starting) begin
                            err_runt      <= 1'b0;
                            err_oversize  <= 1'b0;
                            err_truncated <= 1'b0;
                        end
                        for (int k = 0; k < TAG_SLOTS; k++) begin
                            tpid_hi_q[k] <= tpid_hi_d[k];
                            tpid_lo_q[k] <= tpid_lo_d[k];
                        end
                        vlan_tags <= tags_next;
                        hdr_len   <= hdr_len_next;
                        if (hdr_complete) header_done <= 1'b1;
                        if (tlast) begin
                            state         <= END;
                            frame_end     <= 1'b1;
                            frame_len     <= new_count;
                            err_runt      <= runt_now;
                            err_oversize  <= over_now;
                            err_truncated <= !hdr_complete;
                        end else begin
                            state <= hdr_complete ? PAYLOAD : HEADER;
                        end
                    end
                    PAYLOAD, DISCARD: begin
                        if (tlast) begin
                            state        <= END;
                            frame_end    <= 1'b1;
                            frame_len    <= new_count;
                            err_runt     <= runt_now;
                            err_oversize <= over_now;
                        end else if (over_now) begin
                            state        <= DISCARD;
                            err_oversize <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_tracker_fsm.sv
// Bench for frame_tracker_fsm. It runs three instances side by side:
// 1-byte beats, 4-byte beats, and 8-byte beats limited to one VLAN tag.
// Directed and random frames go in, and expected per-frame results are
// queued and compared as each frame_end appears.
module tb_frame_tracker_fsm;

    localparam int CW = 11;
    localparam int RW = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] tdata_w;
    logic [7:0]  tkeep_w;
    logic        tlast_w;
    logic        acc1, acc4, acc8;

    logic fs1, ih1, ip1, hd1, fe1, er1, eo1, et1;
    logic fs4, ih4, ip4, hd4, fe4, er4, eo4, et4;
    logic fs8, ih8, ip8, hd8, fe8, er8, eo8, et8;
    logic [4:0]    hl1, hl4, hl8;
    logic [1:0]    vt1, vt4, vt8;
    logic [CW-1:0] fl1, fl4, fl8;
    logic [2:0]    st1, st4, st8;

    frame_tracker_fsm #(.DATA_BYTES(1)) u_d1 (
        .clk(clk), .rst(rst), .beat_accept(acc1), .tdata(tdata_w[7:0]), .tkeep(tkeep_w[0:0]),
        .tlast(tlast_w), .frame_start(fs1), .in_header(ih1), .in_payload(ip1), .header_done(hd1),
        .hdr_len(hl1), .vlan_tags(vt1), .frame_len(fl1), .frame_end(fe1), .err_runt(er1),
        .err_oversize(eo1), .err_truncated(et1), .state_dbg(st1));

    frame_tracker_fsm #(.DATA_BYTES(4)) u_d4 (
        .clk(clk), .rst(rst), .beat_accept(acc4), .tdata(tdata_w[31:0]), .tkeep(tkeep_w[3:0]),
        .tlast(tlast_w), .frame_start(fs4), .in_header(ih4), .in_payload(ip4), .header_done(hd4),
        .hdr_len(hl4), .vlan_tags(vt4), .frame_len(fl4), .frame_end(fe4), .err_runt(er4),
        .err_oversize(eo4), .err_truncated(et4), .state_dbg(st4));

    frame_tracker_fsm #(.DATA_BYTES(8), .MAX_VLAN_TAGS(1)) u_d8 (
        .clk(clk), .rst(rst), .beat_accept(acc8), .tdata(tdata_w), .tkeep(tkeep_w),
        .tlast(tlast_w), .frame_start(fs8), .in_header(ih8), .in_payload(ip8), .header_done(hd8),
        .hdr_len(hl8), .vlan_tags(vt8), .frame_len(fl8), .frame_end(fe8), .err_runt(er8),
        .err_oversize(eo8), .err_truncated(et8), .state_dbg(st8));

    // Expected record: {frame_len, hdr_len, vlan_tags, runt, oversize, truncated,
    //                   header_done beat (0 = none), bytes at DISCARD entry (0 = none)}
    logic [RW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [7:0] frm [0:2047];
    int  m_beats [3];
    int  m_bytes [3];
    int  m_hd    [3];
    int  m_disc  [3];
    bit  m_active[3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rand_tpid();
        return ($urandom_range(0, 1) == 0) ? 16'h8100 : 16'h88A8;
    endfunction

    function automatic bit is_tpid(input logic [7:0] hi, input logic [7:0] lo);
        return ({hi, lo} == 16'h8100) || ({hi, lo} == 16'h88A8);
    endfunction

    task automatic build_frame(input int len, input int ntags,
                               input logic [15:0] tp0, input logic [15:0] tp1, input logic [15:0] tp2);
        logic [15:0] tps [3];
        int p;
        tps[0] = tp0; tps[1] = tp1; tps[2] = tp2;
        for (int i = 0; i < 2048; i++) frm[i] = 8'($urandom_range(0, 255));
        p = 12;
        for (int t = 0; t < ntags; t++) begin
            frm[p] = tps[t][15:8];
            frm[p+1] = tps[t][7:0];
            p += 4;
        end
        frm[p] = 8'h08;
        frm[p+1] = 8'h00;
    endtask

    function automatic logic [RW-1:0] model(input int db, input int maxt, input int len);
        int k, hdr, hd_beat, nbeats, disc, cnt;
        bit complete;
        k = 0;
        while (k < maxt && len > 13 + 4 * k && is_tpid(frm[12+4*k], frm[13+4*k])) k++;
        hdr = 14 + 4 * k;
        complete = (len >= hdr);
        hd_beat = complete ? (hdr + db - 1) / db : 0;
        nbeats = (len + db - 1) / db;
        disc = 0;
        if (complete) begin
            for (int b = hd_beat + 1; b < nbeats; b++) begin
                cnt = b * db;
                if (disc == 0 && cnt > 1522) disc = cnt;
            end
        end
        return {11'(len), 5'(hdr), 2'(k), (len < 60), (len > 1522), !complete, 8'(hd_beat), 11'(disc)};
    endfunction

    task automatic set_acc(input int s, input logic v);
        case (s)
            0: acc1 = v;
            1: acc4 = v;
            default: acc8 = v;
        endcase
    endtask

    task automatic send_frame(input int s, input int len, input int gap_max, input bit b2b, input int abort_at);
        int db, nb, g;
        db = (s == 0) ? 1 : (s == 1) ? 4 : 8;
        nb = (abort_at > 0) ? abort_at : (len + db - 1) / db;
        for (int b = 0; b < nb; b++) begin
            tdata_w = '0;
            tkeep_w = '0;
            for (int i = 0; i < db; i++) begin
                if (b * db + i < len) begin
                    tdata_w[8*i +: 8] = frm[b*db+i];
                    tkeep_w[i] = 1'b1;
                end
            end
            tlast_w = (abort_at == 0) && (b == nb - 1);
            set_acc(s, 1'b1);
            @(posedge clk); #1;
            if (b != nb - 1 && gap_max > 0) begin
                g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    set_acc(s, 1'b0);
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
        end
        if (!b2b && abort_at == 0) set_acc(s, 1'b0);
    endtask

    task automatic run(input int s, input int len, input int ntags, input logic [15:0] tp0,
                       input logic [15:0] tp1, input logic [15:0] tp2, input int gap, input bit b2b);
        int db, maxt;
        db = (s == 0) ? 1 : (s == 1) ? 4 : 8;
        maxt = (s == 2) ? 1 : 2;
        build_frame(len, ntags, tp0, tp1, tp2);
        exp_q.push_back(model(db, maxt, len));
        send_frame(s, len, gap, b2b, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL drain: %0d frames outstanding, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Observes one instance at the falling edge and scores completed frames.
    task automatic mon(input int s, input logic fs, input logic ih, input logic ip, input logic hd,
                       input logic fe, input logic ba, input logic er, input logic eo, input logic et,
                       input logic [4:0] hl, input logic [1:0] vt, input logic [CW-1:0] fl,
                       input logic [2:0] st, input int nb);
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        if (rst) begin
            chk("reset_outputs", {fs, ih, ip, hd, fe, er, eo, et, hl, vt, fl},
                {8'h00, 5'd14, 2'd0, 11'd0});
            m_active[s] = 1'b0;
            m_beats[s] = 0;
            m_bytes[s] = 0;
            m_hd[s] = 0;
            m_disc[s] = 0;
            return;
        end
        if (m_active[s] && m_hd[s] == 0 && !hd && !fe) chk("in_header", {ih, ip}, 2'b10);
        if (hd && !fe) chk("in_payload_after_header", {ih, ip}, 2'b01);
        if (hd) m_hd[s] = m_beats[s];
        if (st == 3'd3 && m_disc[s] == 0) m_disc[s] = m_bytes[s];
        if (fe) begin
            chk("end_phase", {ih, ip}, 2'b00);
            if (ba) chk("b2b_frame_start", fs, 1'b1);
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_frame_end: observed frame_end on dut %0d, required none", s);
            end
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                got = {fl, hl, vt, er, eo, et, 8'(m_hd[s]), 11'(m_disc[s])};
                chk("frame_record", got, exp);
            end
            m_active[s] = 1'b0;
        end
        if (fs) begin
            m_active[s] = 1'b1;
            m_beats[s] = 0;
            m_bytes[s] = 0;
            m_hd[s] = 0;
            m_disc[s] = 0;
        end
        if (ba) begin
            m_beats[s]++;
            m_bytes[s] += nb;
        end
    endtask

    initial begin
        rst = 1'b1;
        acc1 = 1'b0; acc4 = 1'b0; acc8 = 1'b0;
        tdata_w = '0; tkeep_w = '0; tlast_w = 1'b0;
        for (int s = 0; s < 3; s++) begin
            m_active[s] = 1'b0; m_beats[s] = 0; m_bytes[s] = 0; m_hd[s] = 0; m_disc[s] = 0;
        end
        fork
            forever begin
                @(negedge clk);
                mon(0, fs1, ih1, ip1, hd1, fe1, acc1, er1, eo1, et1, hl1, vt1, fl1, st1, $countones(tkeep_w[0:0]));
                mon(1, fs4, ih4, ip4, hd4, fe4, acc4, er4, eo4, et4, hl4, vt4, fl4, st4, $countones(tkeep_w[3:0]));
                mon(2, fs8, ih8, ip8, hd8, fe8, acc8, er8, eo8, et8, hl8, vt8, fl8, st8, $countones(tkeep_w));
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Untagged 64-byte frame, 1-byte beats.
        run(0, 64, 0, 16'h0, 16'h0, 16'h0, 0, 1'b0);
        drain();
        // Double-tagged 68-byte frame, 4-byte beats with idle gaps.
        run(1, 68, 2, 16'h88A8, 16'h8100, 16'h0, 2, 1'b0);
        drain();
        // Three stacked TPIDs, only one tag resolved.
        run(2, 70, 3, 16'h8100, 16'h8100, 16'h8100, 1, 1'b0);
        drain();
        // Oversize frame, then a runt that ends inside the header.
        run(0, 1600, 0, 16'h0, 16'h0, 16'h0, 0, 1'b0);
        drain();
        run(0, 10, 0, 16'h0, 16'h0, 16'h0, 1, 1'b0);
        drain();
        // Back-to-back frames, each first beat taken during END.
        run(1, 64, 0, 16'h0, 16'h0, 16'h0, 1, 1'b1);
        run(1, 61, 1, 16'h8100, 16'h0, 16'h0, 1, 1'b1);
        run(1, 30, 0, 16'h0, 16'h0, 16'h0, 0, 1'b0);
        drain();
        // Header completes on the last beat.
        run(2, 14, 0, 16'h0, 16'h0, 16'h0, 0, 1'b0);
        drain();
        // Length boundaries around the oversize threshold.
        run(1, 1523, 0, 16'h0, 16'h0, 16'h0, 0, 1'b0);
        drain();
        run(1, 1522, 1, 16'h88A8, 16'h0, 16'h0, 0, 1'b0);
        drain();

        // Reset in the middle of a tagged frame, with a beat still offered.
        build_frame(40, 1, 16'h8100, 16'h0, 16'h0);
        send_frame(0, 40, 0, 1'b0, 20);
        rst = 1'b1;
        @(posedge clk); #1;
        acc1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run(0, 80, 2, 16'h8100, 16'h88A8, 16'h0, 1, 1'b0);
        drain();

        // Random frames on the wide instances.
        for (int r = 0; r < 6; r++) begin
            run(2, $urandom_range(10, 160), $urandom_range(0, 3), rand_tpid(), rand_tpid(), rand_tpid(), 2, 1'b0);
            drain();
            run(1, $urandom_range(10, 160), $urandom_range(0, 3), rand_tpid(), rand_tpid(), rand_tpid(), 2, 1'b0);
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_tracker_fsm.md
FRAME_TRACKER_FSM -- requirements
Module: frame_tracker_fsm

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 1, meaning bytes per beat; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have parameter MAX_VLAN_TAGS, default 2, meaning the maximum number of stacked VLAN tags resolved; legal values are 0 to 2.
REQ-003 SHALL have parameter MIN_FRAME_BYTES, default 60, meaning the runt threshold.
REQ-004 SHALL have parameter MAX_FRAME_BYTES, default 1522, meaning the oversize threshold.
REQ-005 SHALL have parameter CNT_W, default $clog2(MAX_FRAME_BYTES+DATA_BYTES+1), meaning the width of the byte counter.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port beat_accept, input, 1 bit: tvalid && tready of the monitored stream.
REQ-009 SHALL have port tdata, input, 8*DATA_BYTES bits: beat data, with lane 0 as the earliest byte.
REQ-010 SHALL have port tkeep, input, DATA_BYTES bits: byte enables, contiguous from lane 0; all ones on non-last beats.
REQ-011 SHALL have port tlast, input, 1 bit: the last beat of the frame.
REQ-012 SHALL have port frame_start, output, 1 bit: combinational pulse on the first accepted beat of a frame.
REQ-013 SHALL have ports in_header and in_payload, outputs, 1 bit each: state indicators.
REQ-014 SHALL have port header_done, output, 1 bit: registered one-cycle pulse.
REQ-015 SHALL have port hdr_len, output, 5 bits: resolved L2 header length, 14/18/22.
REQ-016 SHALL have port vlan_tags, output, 2 bits: number of detected tags.
REQ-017 SHALL have port frame_len, output, CNT_W bits: total accepted bytes of the last frame.
REQ-018 SHALL have ports frame_end, err_runt, err_oversize and err_truncated, outputs, 1 bit each: end-of-frame pulse plus error flags.

Function
REQ-019 SHALL implement states IDLE, HEADER, PAYLOAD, DISCARD and END.
REQ-020 byte_count SHALL add popcount(tkeep) on every beat_accept, starting from 0 at frame start.
- Absolute offset of lane i = byte_count + i.
REQ-021 Tag k (k < MAX_VLAN_TAGS) SHALL be detected when offsets 12+4k and 13+4k equal 0x8100 or 0x88A8, and tag k-1 was detected if k > 0.
- Each detected tag adds 4 to hdr_len (base 14).
- Bytes split across beats SHALL be resolved with registered partial state.
REQ-022 The header SHALL be complete on the accepted beat where the updated count reaches the current hdr_len and the TPID field at offset hdr_len-2 is non-TPID, or tags equal MAX_VLAN_TAGS.
REQ-023 IDLE: beat_accept SHALL assert frame_start and go to HEADER, or to END with err_truncated set if tlast is also high.
REQ-024 HEADER transitions SHALL be:
- header completes -> PAYLOAD, with header_done pulsing the next cycle;
- tlast on the completing beat -> END, with header_done still pulsing and no truncation;
- tlast before completion -> END, with err_truncated set.
REQ-025 PAYLOAD: tlast SHALL go to END; otherwise, if the updated count exceeds MAX_FRAME_BYTES, it SHALL go to DISCARD with err_oversize set.
REQ-026 DISCARD SHALL hold until a beat with tlast, then go to END; byte_count SHALL saturate at 2^CNT_W-1.
REQ-027 END SHALL last exactly one cycle with frame_end=1, and frame_len SHALL hold the final count.
- err_runt SHALL be 1 if frame_len < MIN_FRAME_BYTES.
- err_oversize SHALL be 1 if frame_len > MAX_FRAME_BYTES, including when the overflowing beat carried tlast.
REQ-028 A beat_accept in END SHALL be the first beat of the next frame: frame_start=1 and IDLE rules applied, with no lost beat.
REQ-029 Error flags, hdr_len, vlan_tags and frame_len SHALL hold from END until the next frame_start, and SHALL then clear to 0/14/0/held respectively.
- frame_len updates only in END.
REQ-030 in_header SHALL equal 1 only in HEADER, and in_payload only in PAYLOAD or DISCARD.
REQ-031 Beats without beat_accept SHALL change no state or counter.

Reset
REQ-032 While rst=1, state SHALL be IDLE and byte_count 0.
- Outputs SHALL be 0, except hdr_len=14.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no frame_end pulse; the next accepted beat SHALL start a new frame.
REQ-034 Deassertion SHALL take effect on the next clk edge with no glitch on frame_start.

Verification
REQ-035 DATA_BYTES=1, untagged 64-byte frame -> the following responses SHALL be observed:
- frame_start on beat 1;
- header_done in the cycle after beat 14;
- hdr_len=14, frame_len=64;
- no errors.
REQ-036 DATA_BYTES=4, double-tagged (0x88A8 then 0x8100) 68-byte frame -> vlan_tags=2, hdr_len=22, and header_done after beat 6.
REQ-037 DATA_BYTES=8, MAX_VLAN_TAGS=1, frame with three stacked TPIDs -> vlan_tags=1 and hdr_len=18.
REQ-038 1600-byte frame -> DISCARD entered after byte 1522, and at frame_end err_oversize=1 and frame_len=1600.
REQ-039 10-byte frame with tlast -> err_truncated=1 and err_runt=1, with no header_done.
REQ-040 Back-to-back frames with a beat accepted during END -> frame_start coincident with END, and the second frame_len is correct.
